// File: rtl/apu_pkg.sv
// Shared APU definitions: length lookup, register offsets, control bit index.
package apu_pkg;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  localparam logic [4:0] TRI_CTRL   = 5'd8;
  localparam logic [4:0] TRI_UNUSED = 5'd9;
  localparam logic [4:0] TRI_LO     = 5'd10;
  localparam logic [4:0] TRI_HI     = 5'd11;

  localparam int unsigned TRI_CTRL_BIT = 7;

  // Register select within a channel's four-byte window.
  typedef enum logic [1:0] {
    SEL_CTRL   = 2'd0,
    SEL_UNUSED = 2'd1,
    SEL_LO     = 2'd2,
    SEL_HI     = 2'd3
  } chan_reg_e;

endpackage

// File: rtl/triangle_regs_if.sv
// CPU write bus into the triangle register block.
interface triangle_regs_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/length_counter.sv
// APU channel length counter: table load, half-frame decrement, disable clear.
module length_counter
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic [4:0] index,
  input  logic       halt,
  input  logic       hframe_tick,
  output logic [7:0] count,
  output logic       nz
);

  // Disable beats load, load beats decrement; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (load) begin
      count <= LEN_TABLE[index];
    end else if (hframe_tick && (count != '0) && !halt) begin
      count <= count - 8'd1;
    end
  end

  assign nz = (count != '0);

endmodule

// File: rtl/triangle_regs.sv
// Triangle channel register capture, linear counter and output gate.
module triangle_regs
  import apu_pkg::*;
#(
  parameter logic [4:0] BASE_OFF = 5'h08
) (
  input  logic                  clk,
  input  logic                  rst,
  triangle_regs_if.slave        bus,
  input  logic                  ch_enable,
  input  logic                  qframe_tick,
  input  logic                  hframe_tick,
  output logic [7:0]            r4008,
  output logic [7:0]            r4009,
  output logic [7:0]            r400a,
  output logic [7:0]            r400b,
  output logic [6:0]            linear_cnt,
  output logic [7:0]            length_cnt,
  output logic                  length_nz,
  output logic                  active
);

  logic [4:0] rel_off;
  logic       hit;
  chan_reg_e  sel;
  logic       wr_hi;
  logic       reload_flag;

  // Offsets below BASE_OFF wrap to large values, so one range test suffices.
  assign rel_off = bus.wr_addr - BASE_OFF;
  assign hit     = bus.wr_en && (rel_off[4:2] == 3'd0);
  assign sel     = chan_reg_e'(rel_off[1:0]);
  assign wr_hi   = hit && (sel == SEL_HI);

  // Capture CPU writes into the four channel registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r4008 <= '0;
      r4009 <= '0;
      r400a <= '0;
      r400b <= '0;
    end else if (hit) begin
      case (sel)
        SEL_CTRL:   r4008 <= bus.wr_data;
        SEL_UNUSED: r4009 <= bus.wr_data;
        SEL_LO:     r400a <= bus.wr_data;
        SEL_HI:     r400b <= bus.wr_data;
        default:    ;
      endcase
    end
  end

  // Linear counter and reload flag; ticks see pre-write r4008, a $400B write sets the flag last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      linear_cnt  <= '0;
      reload_flag <= 1'b0;
    end else begin
      if (qframe_tick) begin
        if (reload_flag) begin
          linear_cnt <= r4008[6:0];
        end else if (linear_cnt != '0) begin
          linear_cnt <= linear_cnt - 7'd1;
        end
        if (!r4008[TRI_CTRL_BIT]) begin
          reload_flag <= 1'b0;
        end
      end
      if (wr_hi) begin
        reload_flag <= 1'b1;
      end
    end
  end

  length_counter u_length (
    .clk         (clk),
    .rst         (rst),
    .enable      (ch_enable),
    .load        (wr_hi),
    .index       (bus.wr_data[7:3]),
    .halt        (r4008[TRI_CTRL_BIT]),
    .hframe_tick (hframe_tick),
    .count       (length_cnt),
    .nz          (length_nz)
  );

  // Generator gate: both counters must be running.
  assign active = (linear_cnt != '0) && length_nz;

endmodule

// File: tb/tb_triangle_regs.sv
// Self-checking bench for triangle_regs: reference model feeds a scoreboard queue.
module tb_triangle_regs;

  typedef struct packed {
    logic [7:0] r8, r9, ra, rb;
    logic [6:0] lin;
    logic [7:0] len;
    logic       nz, act;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ch_enable = 1'b0;
  logic       qframe_tick = 1'b0;
  logic       hframe_tick = 1'b0;
  logic [7:0] r4008, r4009, r400a, r400b;
  logic [6:0] linear_cnt;
  logic [7:0] length_cnt;
  logic       length_nz, active;

  triangle_regs_if bus ();

  triangle_regs #(.BASE_OFF(5'h08)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ch_enable   (ch_enable),
    .qframe_tick (qframe_tick),
    .hframe_tick (hframe_tick),
    .r4008       (r4008),
    .r4009       (r4009),
    .r400a       (r400a),
    .r400b       (r400b),
    .linear_cnt  (linear_cnt),
    .length_cnt  (length_cnt),
    .length_nz   (length_nz),
    .active      (active)
  );

  always #5 clk = ~clk;

  logic [7:0] len_tab [32] = '{
    10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
    12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30
  };

  // Reference state
  logic [7:0] m_reg [4];
  logic [6:0] m_lin;
  logic [7:0] m_len;
  logic       m_flag;

  exp_t exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_lin  = '0;
    m_len  = '0;
    m_flag = 1'b0;
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.r8  = m_reg[0];
    e.r9  = m_reg[1];
    e.ra  = m_reg[2];
    e.rb  = m_reg[3];
    e.lin = m_lin;
    e.len = m_len;
    e.nz  = (m_len != 0);
    e.act = (m_len != 0) && (m_lin != 0);
    return e;
  endfunction

  task automatic model_step(input logic we, input logic [4:0] a, input logic [7:0] d,
                            input logic q, input logic h, input logic en);
    logic [7:0] ctrl;
    logic       wr_b;
    ctrl = m_reg[0];
    wr_b = we && (a == 5'd11);
    if (!en)                                m_len = 8'd0;
    else if (wr_b)                          m_len = len_tab[d[7:3]];
    else if (h && m_len != 0 && !ctrl[7])   m_len = m_len - 8'd1;
    if (q) begin
      if (m_flag)          m_lin = ctrl[6:0];
      else if (m_lin != 0) m_lin = m_lin - 7'd1;
      if (!ctrl[7])        m_flag = 1'b0;
    end
    if (wr_b) m_flag = 1'b1;
    if (we && a >= 5'd8 && a <= 5'd11) m_reg[a - 5'd8] = d;
  endtask

  task automatic compare_head();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("r4008", r4008, e.r8);
    chk("r4009", r4009, e.r9);
    chk("r400a", r400a, e.ra);
    chk("r400b", r400b, e.rb);
    chk("linear_cnt", linear_cnt, e.lin);
    chk("length_cnt", length_cnt, e.len);
    chk("length_nz", length_nz, e.nz);
    chk("active", active, e.act);
  endtask

  // One clock of stimulus; outputs compared 1 time unit after the edge.
  task automatic step(input logic we, input logic [4:0] a, input logic [7:0] d,
                      input logic q, input logic h);
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_addr = a;
    bus.wr_data = d;
    qframe_tick = q;
    hframe_tick = h;
    model_step(we, a, d, q, h, ch_enable);
    exp_q.push_back(model_snapshot());
    @(posedge clk);
    #1;
    compare_head();
    bus.wr_en   = 1'b0;
    qframe_tick = 1'b0;
    hframe_tick = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    model_reset();
    #1;
    chk("rst_len", length_cnt, 0);
    chk("rst_active", active, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ch_enable = 1'b1;

    // Reach length 20 / linear 5, then reset asynchronously mid-cycle
    wr(5'd8, 8'h05);
    wr(5'd11, 8'h10);
    step(1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    chk("t1_len_pre", length_cnt, 20);
    chk("t1_lin_pre", linear_cnt, 5);
    rst = 1'b1;
    #1;
    chk("t1_len", length_cnt, 0);
    chk("t1_lin", linear_cnt, 0);
    chk("t1_r4008", r4008, 0);
    chk("t1_r400b", r400b, 0);
    chk("t1_active", active, 0);
    chk("t1_nz", length_nz, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Linear reload then countdown to zero
    wr(5'd8, 8'h05);
    wr(5'd11, 8'h08);
    step(1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    chk("t2_len", length_cnt, 254);
    chk("t2_lin", linear_cnt, 5);
    chk("t2_active", active, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    chk("t2_lin_end", linear_cnt, 0);
    chk("t2_active_end", active, 0);
    chk("t2_len_end", length_cnt, 254);

    // Halt: reload flag persists, length frozen
    wr(5'd8, 8'h85);
    wr(5'd11, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 5'd0, 8'h00, 1'b0, 1'b1);
    end
    chk("t3_lin", linear_cnt, 5);
    chk("t3_len", length_cnt, 10);

    // Length saturates at zero
    wr(5'd8, 8'h00);
    wr(5'd11, 8'h18);
    chk("t4_len0", length_cnt, 2);
    step(1'b0, 5'd0, 8'h00, 1'b0, 1'b1);
    chk("t4_len1", length_cnt, 1);
    chk("t4_nz1", length_nz, 1);
    step(1'b0, 5'd0, 8'h00, 1'b0, 1'b1);
    chk("t4_len2", length_cnt, 0);
    chk("t4_nz2", length_nz, 0);
    step(1'b0, 5'd0, 8'h00, 1'b0, 1'b1);
    chk("t4_len3", length_cnt, 0);

    // Load beats half-frame; disable beats load but flag still set
    wr(5'd8, 8'h03);
    step(1'b1, 5'd11, 8'h20, 1'b0, 1'b1);
    chk("t5_len_load", length_cnt, 40);
    step(1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    chk("t5_lin_dec", linear_cnt, 2);
    ch_enable = 1'b0;
    step(1'b1, 5'd11, 8'h20, 1'b0, 1'b1);
    chk("t5_len_dis", length_cnt, 0);
    step(1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    chk("t5_flag_reload", linear_cnt, 3);
    ch_enable = 1'b1;

    // Write with quarter tick: tick sees old flag, flag ends set
    step(1'b1, 5'd11, 8'h08, 1'b1, 1'b0);
    chk("t5q_lin", linear_cnt, 2);
    step(1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    chk("t5q_reload", linear_cnt, 3);

    // Out-of-window offsets ignored; in-window visible next clock
    wr(5'd7, 8'hAA);
    wr(5'd12, 8'h55);
    chk("t6_r4008", r4008, 8'h03);
    wr(5'd10, 8'hFD);
    chk("t6_r400a", r400a, 8'hFD);
    wr(5'd11, 8'hF9);
    chk("t6_r400b", r400b, 8'hF9);
    chk("t6_len", length_cnt, 30);
    wr(5'd9, 8'h5A);
    chk("t6_r4009", r4009, 8'h5A);

    // Mixed random traffic against the model
    for (int i = 0; i < 200; i++) begin
      ch_enable = ($urandom_range(0, 15) != 0);
      step(($urandom_range(0, 2) == 0), 5'($urandom_range(6, 13)), 8'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
